// File: rtl/countdown_pkg.sv
// Shared types and defaults for the countdown timer.
// State encoding and default counter width.
package countdown_pkg;

  localparam int CD_WIDTH = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot / auto-reload modes.
// Terminal count pulses tc; busy/done decode the state register.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH = CD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic             start,
  input  logic             enable,
  input  logic             stop,
  input  logic             auto_reload,
  input  logic             ack,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] count_n;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] reload_n;
  logic             tc_n;
  logic             rl_nz;

  assign rl_nz = (reload_reg != '0);

  always_comb begin
    state_n  = state;
    count_n  = count;
    reload_n = reload_reg;
    tc_n     = 1'b0;
    if (load) begin
      count_n  = data;
      reload_n = data;
      state_n  = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            if (count != '0) begin
              state_n = ST_RUN;
            end else begin
              state_n = ST_DONE;
              tc_n    = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_n = ST_IDLE;
          end else if (enable) begin
            if (count > WIDTH'(1)) begin
              count_n = count - WIDTH'(1);
            end else if (auto_reload && rl_nz) begin
              count_n = reload_reg;
              tc_n    = 1'b1;
            end else begin
              // count==0 cannot reach RUN; treat it as terminal too
              count_n = '0;
              state_n = ST_DONE;
              tc_n    = 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (start) begin
            count_n = reload_reg;
            if (rl_nz) begin
              state_n = ST_RUN;
            end else begin
              tc_n = 1'b1;
            end
          end else if (ack) begin
            state_n = ST_IDLE;
          end
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state      <= ST_IDLE;
      count      <= '0;
      reload_reg <= '0;
      tc         <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      reload_reg <= reload_n;
      tc         <= tc_n;
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter: WIDTH, 5, bit width of count, data and reload register.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_  input  1  asynchronous active-low reset.
REQ-004 Port: data  input  WIDTH  parallel load value for count and reload register.
REQ-005 Port: load  input  1  capture data into count and reload register.
REQ-006 Port: start  input  1  begin countdown from current count (IDLE) or reload value (DONE).
REQ-007 Port: enable  input  1  decrement qualifier in RUN; low = hold.
REQ-008 Port: stop  input  1  abort RUN, return to IDLE holding count.
REQ-009 Port: auto_reload  input  1  periodic mode; reload instead of terminating.
REQ-010 Port: ack  input  1  clears done in DONE.
REQ-011 Port: count  output  WIDTH  current counter value (registered).
REQ-012 Port: busy  output  1  high while state is RUN.
REQ-013 Port: done  output  1  high while state is DONE (level, held until ack/start/load).
REQ-014 Port: tc  output  1  one-cycle registered pulse on every terminal count.

Function
REQ-015 States SHALL be IDLE, RUN, DONE; busy and done SHALL be decoded from registered state only.
REQ-016 load SHALL have priority over all other inputs in every state: count<=data, reload_reg<=data, state<=IDLE, tc<=0.
REQ-017 IDLE + start + count!=0 SHALL go to RUN next cycle, count unchanged on that edge.
REQ-018 IDLE + start + count==0 SHALL go to DONE with tc=1 for one cycle.
REQ-019 RUN + enable + count>1 SHALL decrement count by 1; RUN + enable low SHALL hold count and state.
REQ-020 RUN + enable + count==1 + auto_reload low (or reload_reg==0) SHALL set count<=0, state<=DONE, tc<=1.
REQ-021 RUN + enable + count==1 + auto_reload high + reload_reg!=0 SHALL set count<=reload_reg, stay RUN, tc<=1; period = reload_reg enabled cycles.
REQ-022 RUN + stop SHALL go to IDLE with count held; stop outranks enable and terminal count on the same edge; no tc.
REQ-023 DONE + start SHALL set count<=reload_reg and go to RUN (to DONE with tc if reload_reg==0); start outranks ack.
REQ-024 DONE + ack (no start) SHALL go to IDLE, count stays 0.
REQ-025 start in RUN, ack outside DONE, stop outside RUN SHALL be ignored.
REQ-026 Decrement SHALL never wrap below 0; count SHALL never exceed 2^WIDTH-1.
REQ-027 tc SHALL be low on all edges not named in REQ-018/020/021/023.

Reset
REQ-028 rst_ low SHALL immediately (asynchronously) force count=0, reload_reg=0, state=IDLE, busy=0, done=0, tc=0.
REQ-029 rst_ asserted mid-RUN SHALL discard the countdown; first edge after deassertion SHALL behave as IDLE with count=0.

Structure
REQ-030 Package countdown_pkg SHALL hold the state enum typedef and the default WIDTH constant.
REQ-031 Single module; no sub-module; next-state/next-count logic in one combinational block, registers in one asynchronous-reset sequential block.

Verification
REQ-032 load data=5, start, enable high -> busy next cycle, count 5,4,3,2,1,0; tc and done on 0; busy low.
REQ-033 load 3, auto_reload=1, start, enable high for 9 cycles -> count 3,2,1,3,2,1,3,2,1; tc every 3rd cycle; done never high.
REQ-034 load 4, start, enable toggled 1,0,1,0 -> count decrements only on enabled edges; stop at count 2 -> IDLE, count 2, no tc.
REQ-035 In DONE: assert start and ack together -> RUN with count=reload_reg; ack alone -> IDLE, count 0, done low.
REQ-036 load 7 and start same edge -> IDLE, count 7; load during RUN at count 3 with data=6 -> IDLE, count 6, reload 6.
REQ-037 rst_ low asynchronously mid-RUN at count 9 (WIDTH=5) -> count, busy, done, tc all 0 before next clk edge; start after release with count 0 -> DONE + tc.
